prbs7_chk32b: RTL

- Receive-side checker for the 32-bit-per-clock PRBS7 stream (polynomial x^7+x^6+1) used in the GBCR2 SEU/SEE link test.
- Sits after the deserializer/word aligner in the KC705 fabric.
- Self-synchronises from the incoming data with no seed exchange. Tracks lock and counts bit and word errors for SEU accounting.
- Bit ordering: dataIn[31] is the earliest bit (x[n] = dataIn[31-n]).

---
 rtl/prbs7_pkg.sv | 17 +
 rtl/prbs7_popcnt32.sv | 15 +
 rtl/prbs7_chk32b.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/prbs7_pkg.sv
// Shared constants and types for the 32-bit PRBS7 (x^7+x^6+1) receive checker.
package prbs7_pkg;

    localparam int WORD_W      = 32;
    localparam int TAIL_W      = 7;
    localparam int PRBS7_TAP_A = 7;
    localparam int PRBS7_TAP_B = 6;

    // First word produced by the generator when seeded with 7'h7F
    localparam logic [WORD_W-1:0] PRBS7_FIRST_WORD = 32'hFE041851;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/prbs7_popcnt32.sv
// Combinational population count of a 32-bit vector.
module prbs7_popcnt32 (
    input  logic [31:0] bits,
    output logic [5:0]  count
);

    // Sum the set bits
    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + 6'(bits[i]);
        end
    end

endmodule

// File: rtl/prbs7_chk32b.sv
// Self-synchronising PRBS7 checker: stage 1 scores each word against the
// recurrence, stage 2 tracks lock and accumulates SEU error statistics.
module prbs7_chk32b
    import prbs7_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             dataValid,
    input  logic [31:0]      dataIn,
    input  logic             clrCnt,
    output logic             errValid,
    output logic [5:0]       errBits,
    output logic             errFlag,
    output logic             locked,
    output logic [CNT_W-1:0] errBitCnt,
    output logic [CNT_W-1:0] errWordCnt,
    output logic [CNT_W-1:0] wordCnt,
    output logic [15:0]      lockLossCnt
);

    localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [TAIL_W-1:0]        tail;
    logic                     tail_valid;
    logic [WORD_W+TAIL_W-1:0] window;
    logic [WORD_W-1:0]        mismatch;
    logic [5:0]               pop;
    logic [CNT_W:0]           bit_sum;
    lock_state_e              state;
    logic [7:0]               good_run;
    logic [7:0]               bad_run;
    logic                     unlock_now;

    // Earliest bit sits at the top; window bit i+7 / i+6 are 7 / 6 bits earlier
    assign window = {tail, dataIn};

    // Each received bit must equal the XOR of its two tap predecessors
    always_comb begin
        mismatch = '0;
        for (int i = 0; i < WORD_W; i++) begin
            mismatch[i] = window[i] ^ window[i+PRBS7_TAP_A] ^ window[i+PRBS7_TAP_B];
        end
    end

    prbs7_popcnt32 u_popcnt (
        .bits  (mismatch),
        .count (pop)
    );

    // Wide enough to detect overflow so the bit counter clamps instead of wrapping
    assign bit_sum    = {1'b0, errBitCnt} + {{(CNT_W-5){1'b0}}, errBits};
    assign unlock_now = (state == LOCKED) && errValid && errFlag && (bad_run == UNLOCK_LAST);

    // Stage 1: tail tracking and per-word scoring; first word after reset only seeds
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            tail       <= '0;
            tail_valid <= 1'b0;
            errValid   <= 1'b0;
            errBits    <= '0;
            errFlag    <= 1'b0;
        end else begin
            errValid <= 1'b0;
            if (dataValid) begin
                tail       <= dataIn[TAIL_W-1:0];
                tail_valid <= 1'b1;
                if (tail_valid) begin
                    errValid <= 1'b1;
                    errBits  <= pop;
                    // An all-zero window satisfies the recurrence but is a dead link
                    errFlag  <= (pop != 6'd0) || (window == '0);
                end
            end
        end
    end

    // Stage 2: lock FSM plus saturating statistics, driven by the registered score
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            good_run    <= '0;
            bad_run     <= '0;
            errBitCnt   <= '0;
            errWordCnt  <= '0;
            wordCnt     <= '0;
            lockLossCnt <= '0;
        end else begin
            if (errValid) begin
                case (state)
                    SEARCH: begin
                        if (errFlag) begin
                            good_run <= '0;
                        end else if (good_run == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_run <= '0;
                        end else begin
                            good_run <= good_run + 8'd1;
                        end
                    end
                    LOCKED: begin
                        if (!errFlag) begin
                            bad_run <= '0;
                        end else if (unlock_now) begin
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            bad_run  <= '0;
                            good_run <= '0;
                        end else begin
                            bad_run <= bad_run + 8'd1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end

            // A clear wins over this cycle's contribution; lock state is not touched
            if (clrCnt) begin
                errBitCnt   <= '0;
                errWordCnt  <= '0;
                wordCnt     <= '0;
                lockLossCnt <= '0;
            end else if (errValid && state == LOCKED) begin
                if (wordCnt != '1) wordCnt <= wordCnt + CNT_ONE;
                if (errFlag) begin
                    if (errWordCnt != '1) errWordCnt <= errWordCnt + CNT_ONE;
                    errBitCnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
                end
                if (unlock_now && lockLossCnt != 16'hFFFF) lockLossCnt <= lockLossCnt + 16'd1;
            end
        end
    end

endmodule
